memshare_monitor_mch: RTL and testbench

Multi-channel, parametrised monitor for SCU.memShare() scheduling. Per channel, it tracks which requests at SHIFT_GEN need two allocation sequences and flags design rules 1–3. Rule evaluation uses a shared pipeline-phase counter whose period is configurable. The block adds a stall input, per-channel pipeline-cycle-begin flags, and optional saturating DRC hit counters for the memShare control units and for verification.

---
 rtl/memShare_config_pkg.sv | 15 +
 rtl/memShare_ch_tracker.sv | 70 +++++++
 rtl/memshare_monitor_mch.sv | 61 ++++++
 tb/tb_memshare_monitor_mch.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/memShare_config_pkg.sv
// Shared constants and types for the memShare scheduling monitor.
// Optional hit counters are enabled with the MEMSHARE_MON_CNT_EN macro.
package memShare_config_pkg;

  localparam int MEMSHARE_DRC1    = 0;
  localparam int MEMSHARE_DRC2    = 1;
  localparam int MEMSHARE_DRC3    = 2;
  localparam int MEMSHARE_DRC_NUM = 3;

  localparam int DEFAULT_PIPE_PERIOD = 4;
  localparam int DEFAULT_RUN_LEN     = 3;

  typedef logic [MEMSHARE_DRC_NUM-1:0] drc_flags_t;

endpackage

// File: rtl/memShare_ch_tracker.sv
// One channel of the memShare monitor: two-sequence history, rule flags and,
// when MEMSHARE_MON_CNT_EN is defined, saturating per-rule hit counters.
module memShare_ch_tracker
  import memShare_config_pkg::*;
#(
  parameter int RUN_LEN = DEFAULT_RUN_LEN,
  parameter int CNT_W   = 16
) (
  input  logic                                    sys_clk,
  input  logic                                    rst,
  input  logic                                    en,
  input  logic                                    is_gtr,
  input  logic                                    phase_last,
  input  logic                                    clr_cnt,
  output drc_flags_t                              drc,
  output logic [MEMSHARE_DRC_NUM-1:0][CNT_W-1:0]  cnt,
  output logic                                    cnt_sat
);

  logic [RUN_LEN:0] rd;
  logic             drc1;
  logic             drc2;
  logic             drc3;

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      rd <= '0;
    end else if (en) begin
      rd <= {rd[RUN_LEN-1:0], is_gtr};
    end
  end

  // Flags depend on registers only, so they hold by themselves during a stall.
  always_comb begin
    drc2 = &rd[RUN_LEN-1:0];
    drc3 = drc2 & ~rd[RUN_LEN] & phase_last;
    drc1 = rd[0] & ~drc2 & ~drc3;
    drc  = '0;
    drc[MEMSHARE_DRC1] = drc1;
    drc[MEMSHARE_DRC2] = drc2;
    drc[MEMSHARE_DRC3] = drc3;
  end

`ifdef MEMSHARE_MON_CNT_EN
  localparam logic [CNT_W-1:0] CNT_NEAR = {{(CNT_W-1){1'b1}}, 1'b0};

  always_ff @(posedge sys_clk) begin
    if (rst || clr_cnt) begin
      cnt     <= '0;
      cnt_sat <= 1'b0;
    end else if (en) begin
      for (int r = 0; r < MEMSHARE_DRC_NUM; r++) begin
        if (drc[r] && (cnt[r] != '1)) begin
          cnt[r] <= cnt[r] + 1'b1;
          if (cnt[r] == CNT_NEAR) begin
            cnt_sat <= 1'b1;
          end
        end
      end
    end
  end
`else
  logic unused_clr_cnt;

  assign unused_clr_cnt = clr_cnt;
  assign cnt            = '0;
  assign cnt_sat        = 1'b0;
`endif

endmodule

// File: rtl/memshare_monitor_mch.sv
// Multi-channel memShare scheduling monitor: shared phase counter plus one
// tracker per channel. Hit counters exist only with MEMSHARE_MON_CNT_EN.
module memshare_monitor_mch
  import memShare_config_pkg::*;
#(
  parameter int CH_NUM      = 2,
  parameter int PIPE_PERIOD = DEFAULT_PIPE_PERIOD,
  parameter int RUN_LEN     = DEFAULT_RUN_LEN,
  parameter int CNT_W       = 16
) (
  input  logic                                               sys_clk,
  input  logic                                               rst,
  input  logic                                               en_i,
  input  logic [CH_NUM-1:0]                                  isGtr_i,
  input  logic                                               clr_cnt_i,
  output drc_flags_t [CH_NUM-1:0]                            is_drc_o,
  output logic [CH_NUM-1:0]                                  pipeCycle_begin_o,
  output logic [$clog2(PIPE_PERIOD)-1:0]                     phase_o,
  output logic [CH_NUM-1:0][MEMSHARE_DRC_NUM-1:0][CNT_W-1:0] drc_cnt_o,
  output logic [CH_NUM-1:0]                                  drc_cnt_sat_o
);

  localparam int               PHASE_W    = $clog2(PIPE_PERIOD);
  localparam logic [PHASE_W-1:0] PHASE_LAST = PHASE_W'(PIPE_PERIOD - 1);

  logic phase_last;

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      phase_o <= '0;
    end else if (en_i) begin
      if (phase_o == PHASE_LAST) begin
        phase_o <= '0;
      end else begin
        phase_o <= phase_o + 1'b1;
      end
    end
  end

  assign phase_last = (phase_o == PHASE_LAST);

  for (genvar c = 0; c < CH_NUM; c++) begin : g_ch
    memShare_ch_tracker #(
      .RUN_LEN (RUN_LEN),
      .CNT_W   (CNT_W)
    ) u_tracker (
      .sys_clk    (sys_clk),
      .rst        (rst),
      .en         (en_i),
      .is_gtr     (isGtr_i[c]),
      .phase_last (phase_last),
      .clr_cnt    (clr_cnt_i),
      .drc        (is_drc_o[c]),
      .cnt        (drc_cnt_o[c]),
      .cnt_sat    (drc_cnt_sat_o[c])
    );

    assign pipeCycle_begin_o[c] = is_drc_o[c][MEMSHARE_DRC3];
  end

endmodule

// File: tb/tb_memshare_monitor_mch.sv
// Directed self-checking bench for memshare_monitor_mch (defaults, CNT_W=4);
// counter expectations follow MEMSHARE_MON_CNT_EN.
module tb_memshare_monitor_mch;
  import memShare_config_pkg::*;

  localparam int CH_NUM = 2;
  localparam int CNT_W  = 4;
`ifdef MEMSHARE_MON_CNT_EN
  localparam bit CNT_ON = 1'b1;
`else
  localparam bit CNT_ON = 1'b0;
`endif

  logic                                               sys_clk = 1'b0;
  logic                                               rst;
  logic                                               en_i;
  logic [CH_NUM-1:0]                                  isGtr_i;
  logic                                               clr_cnt_i;
  drc_flags_t [CH_NUM-1:0]                            is_drc_o;
  logic [CH_NUM-1:0]                                  pipeCycle_begin_o;
  logic [1:0]                                         phase_o;
  logic [CH_NUM-1:0][MEMSHARE_DRC_NUM-1:0][CNT_W-1:0] drc_cnt_o;
  logic [CH_NUM-1:0]                                  drc_cnt_sat_o;

  int checks = 0;
  int errors = 0;

  memshare_monitor_mch #(
    .CH_NUM      (CH_NUM),
    .PIPE_PERIOD (4),
    .RUN_LEN     (3),
    .CNT_W       (CNT_W)
  ) dut (
    .sys_clk           (sys_clk),
    .rst               (rst),
    .en_i              (en_i),
    .isGtr_i           (isGtr_i),
    .clr_cnt_i         (clr_cnt_i),
    .is_drc_o          (is_drc_o),
    .pipeCycle_begin_o (pipeCycle_begin_o),
    .phase_o           (phase_o),
    .drc_cnt_o         (drc_cnt_o),
    .drc_cnt_sat_o     (drc_cnt_sat_o)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input bit r, input bit e, input logic [1:0] g, input bit c);
    @(negedge sys_clk);
    rst       = r;
    en_i      = e;
    isGtr_i   = g;
    clr_cnt_i = c;
    @(posedge sys_clk);
    #1;
  endtask

  function automatic int cntExp(input int v);
    return CNT_ON ? v : 0;
  endfunction

  // Channel 0 view: flags {drc3,drc2,drc1}, phase, three counters, saturation.
  task automatic checkCh0(input string tag, input logic [2:0] flags, input int ph,
                          input int c1, input int c2, input int c3, input bit sat);
    checkOutput({tag, "_flags"}, is_drc_o[0], flags);
    checkOutput({tag, "_pipe"}, pipeCycle_begin_o[0], flags[2]);
    checkOutput({tag, "_phase"}, phase_o, ph);
    checkOutput({tag, "_cnt1"}, drc_cnt_o[0][MEMSHARE_DRC1], cntExp(c1));
    checkOutput({tag, "_cnt2"}, drc_cnt_o[0][MEMSHARE_DRC2], cntExp(c2));
    checkOutput({tag, "_cnt3"}, drc_cnt_o[0][MEMSHARE_DRC3], cntExp(c3));
    checkOutput({tag, "_sat"}, drc_cnt_sat_o[0], CNT_ON ? sat : 1'b0);
    checkOutput({tag, "_ch1"}, is_drc_o[1], 3'b000);
  endtask

  logic [2:0] ch1_flags [7] = '{3'b001, 3'b001, 3'b000, 3'b001, 3'b001, 3'b010, 3'b010};
  logic       ch1_gtr   [7] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};

  initial begin
    rst = 1'b1; en_i = 1'b0; isGtr_i = '0; clr_cnt_i = 1'b0;
    applyStimulus(1, 1, 2'b00, 0);
    applyStimulus(1, 1, 2'b00, 0);
    checkCh0("reset", 3'b000, 0, 0, 0, 0, 0);
    checkOutput("reset_cnt_all", drc_cnt_o, 0);

    for (int i = 1; i <= 4; i++) begin
      applyStimulus(0, 1, 2'b00, 0);
      checkCh0($sformatf("idle%0d", i), 3'b000, i % 4, 0, 0, 0, 0);
    end

    applyStimulus(1, 1, 2'b00, 0);
    checkOutput("rerst_phase", phase_o, 0);

    applyStimulus(0, 1, 2'b01, 0);
    checkCh0("run1", 3'b001, 1, 0, 0, 0, 0);
    applyStimulus(0, 1, 2'b01, 0);
    checkCh0("run2", 3'b001, 2, 1, 0, 0, 0);
    applyStimulus(0, 1, 2'b01, 0);
    checkCh0("run3", 3'b110, 3, 2, 0, 0, 0);
    applyStimulus(0, 1, 2'b01, 0);
    checkCh0("run4", 3'b010, 0, 2, 1, 1, 0);
    applyStimulus(0, 1, 2'b01, 0);
    checkCh0("run5", 3'b010, 1, 2, 2, 1, 0);

    for (int i = 0; i < 5; i++) begin
      applyStimulus(0, 0, 2'b01, 0);
      checkCh0($sformatf("stall%0d", i), 3'b010, 1, 2, 2, 1, 0);
    end

    // Counting continues from enabled edge 6; DRC2 count saturates at edge 18.
    for (int k = 6; k <= 25; k++) begin
      applyStimulus(0, 1, 2'b01, 0);
      checkCh0($sformatf("sat%0d", k), 3'b010, k % 4, 2, (k - 3 > 15) ? 15 : k - 3, 1, k >= 18);
    end

    applyStimulus(0, 1, 2'b01, 1);
    checkCh0("clr", 3'b010, 2, 0, 0, 0, 0);
    applyStimulus(0, 1, 2'b01, 0);
    checkCh0("postclr", 3'b010, 3, 0, 1, 0, 0);

    applyStimulus(1, 1, 2'b01, 0);
    checkOutput("midrst_flags", is_drc_o, 0);
    checkOutput("midrst_pipe", pipeCycle_begin_o, 0);
    checkOutput("midrst_phase", phase_o, 0);
    checkOutput("midrst_cnt", drc_cnt_o, 0);
    checkOutput("midrst_sat", drc_cnt_sat_o, 0);

    // Channel 1 only: a broken run must not raise DRC2, and DRC3 needs phase 3.
    for (int j = 0; j < 7; j++) begin
      applyStimulus(0, 1, {ch1_gtr[j], 1'b0}, 0);
      checkOutput($sformatf("gap%0d_ch1", j + 1), is_drc_o[1], ch1_flags[j]);
      checkOutput($sformatf("gap%0d_ch0", j + 1), is_drc_o[0], 3'b000);
      checkOutput($sformatf("gap%0d_phase", j + 1), phase_o, (j + 1) % 4);
    end
    checkOutput("gap_cnt1", drc_cnt_o[1][MEMSHARE_DRC1], cntExp(4));
    checkOutput("gap_cnt2", drc_cnt_o[1][MEMSHARE_DRC2], cntExp(1));
    checkOutput("gap_cnt3", drc_cnt_o[1][MEMSHARE_DRC3], cntExp(0));
    checkOutput("gap_pipe1", pipeCycle_begin_o[1], 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
